c_element_handshake_sequencer: RTL

- Synchronous controller that exercises one two-input Muller C-element inside the async project by driving its inputs through repeated four-phase handshakes.
- Samples the element's asynchronous output through a 2-flop synchronizer and checks hold and switch behaviour.
- Counts passes and errors and aborts on timeout.
- Sits between the user-project I/O or Wishbone-side control and the C-element datapath, replacing direct pad-driven stimulus.

---
 rtl/c_element_handshake_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/c_element_handshake_sequencer.sv
// Synchronous four-phase handshake sequencer that exercises a single Muller C-element.
// Drives the inputs A and B, samples the element output through a 2-flop synchronizer, and counts passes, hold errors and timeouts.
module c_element_handshake_sequencer #(
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] run_count_i,
  output logic             c_a_o,
  output logic             c_b_o,
  input  logic             c_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [7:0]       err_cnt_o,
  output logic             timeout_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_A_UP  = 3'd1;
  localparam logic [2:0] ST_B_UP  = 3'd2;
  localparam logic [2:0] ST_A_DN  = 3'd3;
  localparam logic [2:0] ST_B_DN  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [7:0] SETTLE_T  = 8'(SETTLE);
  localparam logic [7:0] TIMEOUT_T = 8'(TIMEOUT);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [7:0]       tmr;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] pass_inc_val;
  logic             y_meta;
  logic             y_s;
  logic             tmr_last;
  logic             run_done;
  logic             start_acc;
  logic             pass_inc;
  logic             err_inc;
  logic             tmo_set;

  // Each timed state lasts exactly its load value: the state acts in the cycle where tmr is 1.
  assign tmr_last     = (tmr == 8'd1);
  assign pass_inc_val = pass_cnt_o + CNT_W'(1);
  assign run_done     = (run_cnt != '0) && (pass_inc_val == run_cnt);

  function automatic logic [7:0] tmr_load(input logic [2:0] s);
    case (s)
      ST_A_UP, ST_A_DN:           tmr_load = SETTLE_T;
      ST_B_UP, ST_B_DN, ST_DRAIN: tmr_load = TIMEOUT_T;
      default:                    tmr_load = 8'd0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt = state;
    start_acc = 1'b0;
    pass_inc  = 1'b0;
    err_inc   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = ST_A_UP;
        end
      end
      ST_A_UP: begin
        if (stop_i) begin
          state_nxt = ST_DRAIN;
        end else if (tmr_last) begin
          err_inc   = y_s;
          state_nxt = ST_B_UP;
        end
      end
      ST_B_UP: begin
        // A timeout takes priority over a stop that arrives in the same cycle.
        if (tmr_last && !y_s) begin
          tmo_set   = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (stop_i) begin
          state_nxt = ST_DRAIN;
        end else if (y_s) begin
          state_nxt = ST_A_DN;
        end
      end
      ST_A_DN: begin
        if (stop_i) begin
          state_nxt = ST_DRAIN;
        end else if (tmr_last) begin
          err_inc   = !y_s;
          state_nxt = ST_B_DN;
        end
      end
      ST_B_DN: begin
        if (!y_s) begin
          pass_inc  = 1'b1;
          state_nxt = (run_done || stop_i) ? ST_DONE : ST_A_UP;
        end else if (tmr_last) begin
          tmo_set   = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (stop_i) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!y_s) begin
          state_nxt = ST_DONE;
        end else if (tmr_last) begin
          tmo_set   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // c_y_i is asynchronous; only the second flop is ever observed by the control logic.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      y_meta <= 1'b0;
      y_s    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      y_meta <= c_y_i;
      y_s    <= y_meta;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      tmr        <= 8'd0;
      run_cnt    <= '0;
      c_a_o      <= 1'b0;
      c_b_o      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_cnt_o <= '0;
      err_cnt_o  <= 8'd0;
      timeout_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tmr <= tmr_load(state_nxt);
      end else if (tmr != 8'd0) begin
        tmr <= tmr - 8'd1;
      end

      // Outputs are decoded from the next state so they line up with the state they belong to.
      c_a_o  <= (state_nxt == ST_A_UP) || (state_nxt == ST_B_UP);
      c_b_o  <= (state_nxt == ST_B_UP) || (state_nxt == ST_A_DN);
      busy_o <= (state_nxt != ST_IDLE);
      done_o <= (state_nxt == ST_DONE);

      if (start_acc) begin
        run_cnt    <= run_count_i;
        pass_cnt_o <= '0;
        err_cnt_o  <= 8'd0;
        timeout_o  <= 1'b0;
      end else begin
        if (pass_inc) begin
          pass_cnt_o <= pass_inc_val;
        end
        if (err_inc && (err_cnt_o != 8'hFF)) begin
          err_cnt_o <= err_cnt_o + 8'd1;
        end
        if (tmo_set) begin
          timeout_o <= 1'b1;
        end
      end
    end
  end

endmodule
